// File: rtl/codec_cfg_seq_pkg.sv
// Shared types for the codec configuration sequencer: FSM states,
// WM8731 register map and the default power-up table.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } cfg_state_e;

  localparam logic [6:0] R_LLINE = 7'h00;
  localparam logic [6:0] R_RLINE = 7'h01;
  localparam logic [6:0] R_LHP   = 7'h02;
  localparam logic [6:0] R_RHP   = 7'h03;
  localparam logic [6:0] R_APATH = 7'h04;
  localparam logic [6:0] R_DPATH = 7'h05;
  localparam logic [6:0] R_PWR   = 7'h06;
  localparam logic [6:0] R_DIF   = 7'h07;
  localparam logic [6:0] R_SAMP  = 7'h08;
  localparam logic [6:0] R_ACT   = 7'h09;
  localparam logic [6:0] R_RESET = 7'h0F;

  // Entries past the sent count repeat the activate write.
  localparam logic [6:0] cfg_reg [16] = '{
    R_RESET, R_LLINE, R_RLINE, R_LHP,
    R_APATH, R_DPATH, R_PWR,   R_DIF,
    R_SAMP,  R_ACT,   R_ACT,   R_ACT,
    R_ACT,   R_ACT,   R_ACT,   R_ACT
  };

  localparam logic [8:0] cfg_data [16] = '{
    9'h000, 9'h017, 9'h017, 9'h179,
    9'h012, 9'h000, 9'h000, 9'h042,
    9'h000, 9'h001, 9'h001, 9'h001,
    9'h001, 9'h001, 9'h001, 9'h001
  };

endpackage

// File: rtl/codec_cfg_seq_timer.sv
// cfg_timer: loadable down-counter with enable and zero flag.
// Ports: i_load/i_val load, i_en decrement, o_zero when count is 0.
module cfg_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_en && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/codec_cfg_seq.sv
// Codec power-up sequencer over the I2C go/end handshake: table walk,
// retry, gaps, timeout, progress/error flags and re-run on restart.
// Ports: clk, rst_n, restart; i2c_data/i2c_go out, i2c_end/i2c_ack_err
// in; cfg_busy/cfg_done/cfg_error/cfg_index status.
// Macro CODEC_CFG_VOLUME_EN adds vol_req, vol_value, vol_busy.
module codec_cfg_seq
  import codec_cfg_pkg::*;
#(
  parameter int         NUM_REGS       = 10,
  parameter logic [7:0] DEV_ADDR       = 8'h34,
  parameter int         STARTUP_CYCLES = 1000,
  parameter int         GAP_CYCLES     = 250,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  output logic [23:0] i2c_data,
  output logic        i2c_go,
  input  logic        i2c_end,
  input  logic        i2c_ack_err,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [3:0]  cfg_index
`ifdef CODEC_CFG_VOLUME_EN
  ,
  input  logic        vol_req,
  input  logic [6:0]  vol_value,
  output logic        vol_busy
`endif
);

  localparam int T0   = (STARTUP_CYCLES > 4*GAP_CYCLES) ?
                        STARTUP_CYCLES : 4*GAP_CYCLES;
  localparam int TMAX = (T0 > TIMEOUT_CYCLES) ? T0 : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  cfg_state_e r_state, w_state_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic [3:0]  r_retry, w_rty_nxt;
  logic        r_rpend, w_rpend_nxt;
  logic        r_armed, w_armed_nxt;
  logic        r_go, w_go_nxt;
  logic [23:0] r_data, w_data_nxt;
  logic [23:0] w_word;
  logic        w_tmr_load, w_tmr_en, w_tmr_zero;
  logic [TW-1:0] w_tmr_val;
  logic        w_ok, w_fail, w_give_up;
  logic        w_vmode, w_vsel, w_first, w_last;

  cfg_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_tmr_load),
    .i_en   (w_tmr_en),
    .i_val  (w_tmr_val),
    .o_zero (w_tmr_zero)
  );

`ifdef CODEC_CFG_VOLUME_EN
  logic       r_vmode;
  logic       r_vsel;
  logic [6:0] r_vval;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vmode <= 1'b0;
      r_vsel  <= 1'b0;
      r_vval  <= '0;
    end else if (r_state == ST_DONE && !restart && vol_req) begin
      r_vmode <= 1'b1;
      r_vsel  <= 1'b0;
      r_vval  <= vol_value;
    end else if (r_vmode && w_ok) begin
      r_vsel  <= 1'b1;
      r_vmode <= !r_vsel;
    end else if (w_give_up) begin
      r_vmode <= 1'b0;
    end
  end

  assign w_vmode  = r_vmode;
  assign w_vsel   = r_vsel;
  assign vol_busy = r_vmode;
  assign w_word   = r_vmode ?
    {DEV_ADDR, (r_vsel ? R_RHP : R_LHP), 2'b01, r_vval} :
    {DEV_ADDR, cfg_reg[r_idx], cfg_data[r_idx]};
`else
  assign w_vmode = 1'b0;
  assign w_vsel  = 1'b0;
  assign w_word  = {DEV_ADDR, cfg_reg[r_idx], cfg_data[r_idx]};
`endif

  // Long settle gap only after the codec reset write succeeds.
  assign w_first   = !w_vmode && (r_idx == 4'd0);
  assign w_last    = w_vmode ? w_vsel : (r_idx == 4'(NUM_REGS - 1));
  assign w_give_up = w_fail && !(r_retry < 4'(MAX_RETRY));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_rty_nxt   = r_retry;
    w_rpend_nxt = r_rpend;
    w_armed_nxt = r_armed;
    w_go_nxt    = r_go;
    w_data_nxt  = r_data;
    w_tmr_load  = 1'b0;
    w_tmr_en    = 1'b0;
    w_tmr_val   = '0;
    w_ok        = 1'b0;
    w_fail      = 1'b0;
    unique case (r_state)
      ST_STARTUP: begin
        w_tmr_en = 1'b1;
        // First cycle arms the timer; reset leaves it at zero.
        if (!r_armed) begin
          w_armed_nxt = 1'b1;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TW'(STARTUP_CYCLES - 2);
        end else if (w_tmr_zero) begin
          w_armed_nxt = 1'b0;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_data_nxt  = w_word;
        w_rty_nxt   = '0;
        w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_go_nxt    = 1'b1;
        w_tmr_load  = 1'b1;
        w_tmr_val   = TW'(TIMEOUT_CYCLES - 1);
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_tmr_en = 1'b1;
        // An end coinciding with expiry wins over the timeout.
        if (i2c_end) begin
          w_go_nxt = 1'b0;
          w_ok     = !i2c_ack_err;
          w_fail   = i2c_ack_err;
        end else if (w_tmr_zero) begin
          w_go_nxt = 1'b0;
          w_fail   = 1'b1;
        end
      end
      ST_GAP: begin
        w_tmr_en = 1'b1;
        if (w_tmr_zero) begin
          w_state_nxt = r_rpend ? ST_ISSUE : ST_LOAD;
          w_rpend_nxt = 1'b0;
        end
      end
      ST_DONE: begin
        if (restart) begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_STARTUP;
        end
`ifdef CODEC_CFG_VOLUME_EN
        else if (vol_req) begin
          w_state_nxt = ST_LOAD;
        end
`endif
      end
      ST_ERROR: begin
        if (restart) begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_STARTUP;
        end
      end
      default: w_state_nxt = ST_STARTUP;
    endcase

    if (w_ok) begin
      if (w_last) begin
        w_state_nxt = ST_DONE;
      end else begin
        w_state_nxt = ST_GAP;
        w_tmr_load  = 1'b1;
        w_tmr_val   = w_first ? TW'(4*GAP_CYCLES - 1) :
                                TW'(GAP_CYCLES - 1);
        if (!w_vmode) w_idx_nxt = r_idx + 4'd1;
      end
    end

    if (w_fail) begin
      if (w_give_up) begin
        w_state_nxt = ST_ERROR;
      end else begin
        w_rty_nxt   = r_retry + 4'd1;
        w_rpend_nxt = 1'b1;
        w_state_nxt = ST_GAP;
        w_tmr_load  = 1'b1;
        w_tmr_val   = TW'(GAP_CYCLES - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STARTUP;
      r_idx   <= '0;
      r_retry <= '0;
      r_rpend <= 1'b0;
      r_armed <= 1'b0;
      r_go    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_retry <= w_rty_nxt;
      r_rpend <= w_rpend_nxt;
      r_armed <= w_armed_nxt;
      r_go    <= w_go_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign i2c_data  = r_data;
  assign i2c_go    = r_go;
  assign cfg_index = r_idx;
  assign cfg_done  = (r_state == ST_DONE);
  assign cfg_error = (r_state == ST_ERROR);
  assign cfg_busy  = !(cfg_done || cfg_error) && !w_vmode;

endmodule

// File: doc/codec_cfg_seq.md
Name: codec_cfg_seq

Overview:
- Sequences the audio codec's power-up register configuration over the existing I2C master using a go/end handshake.
- Walks a fixed table of 24-bit words. Each word is {8-bit device address, 7-bit register, 9-bit data}.
- Retries a failed transfer, inserts inter-write gaps, reports progress and errors, and supports re-run on request.
- Sits between the top-level clock domain and the I2C master; replaces free-running configuration loops.

Parameters:
- NUM_REGS, 10, number of table entries sent (1..16).
- DEV_ADDR, 8'h34, codec write address placed in bits [23:16].
- STARTUP_CYCLES, 1000, clk cycles to wait after reset or restart before the first write.
- GAP_CYCLES, 250, idle clk cycles between consecutive writes.
- TIMEOUT_CYCLES, 50000, maximum clk cycles to wait for i2c_end.
- MAX_RETRY, 3, extra attempts per word before the ERROR state.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- restart  in  1  one-cycle pulse; re-runs the full sequence from DONE or ERROR, ignored otherwise.
- i2c_data  out  24  word presented to the I2C master.
- i2c_go  out  1  transfer request level.
- i2c_end  in  1  one-cycle pulse from the master when a transfer completes.
- i2c_ack_err  in  1  sampled with i2c_end; 1 = NACK.
- cfg_busy  out  1  high from reset/restart until DONE or ERROR.
- cfg_done  out  1  high in DONE.
- cfg_error  out  1  high in ERROR.
- cfg_index  out  4  index of the current or last table entry.

Behaviour:
- Reset state: state=STARTUP, counters=0, i2c_go=0, i2c_data=0, cfg_busy=1, cfg_done=0, cfg_error=0, cfg_index=0.
- STARTUP:
  - Count STARTUP_CYCLES, then go to LOAD.
- LOAD (1 cycle):
  - i2c_data <= {DEV_ADDR, reg[idx], data[idx]}.
  - Retry counter=0.
  - Go to ISSUE.
- ISSUE:
  - Set i2c_go=1.
  - Next cycle go to WAIT_END.
  - i2c_go stays high through WAIT_END and drops in the same cycle i2c_end is seen.
- WAIT_END, on i2c_end=1:
  - If i2c_ack_err=0: success.
  - If i2c_ack_err=1: failure.
- WAIT_END, no i2c_end:
  - When the timeout counter reaches TIMEOUT_CYCLES-1: failure. i2c_go drops.
- Success:
  - If idx==NUM_REGS-1, go to DONE.
  - Otherwise idx++ and go to GAP.
- Failure:
  - If retry<MAX_RETRY: retry++, go to GAP, then re-ISSUE the same word without reloading.
  - Otherwise go to ERROR; cfg_index holds the failing entry.
- GAP:
  - Count GAP_CYCLES with i2c_go=0.
  - Then go to LOAD (new word) or ISSUE (retry).
- Entry 0 (codec reset register) gap:
  - The gap after entry 0 is 4*GAP_CYCLES, to allow the codec's internal reset to settle.
- DONE / ERROR:
  - Stable until restart.
  - restart: clear idx, done and error; set busy; go to STARTUP.
  - restart in any other state is ignored.
- Simultaneous events:
  - i2c_end arriving in the same cycle as the timeout expiry counts as an end (not a timeout).
  - i2c_end outside WAIT_END is ignored.
- rst_n assertion mid-transfer forces the reset state immediately; i2c_go drops asynchronously.
- Latency: minimum success path per word is LOAD+ISSUE+1+GAP_CYCLES cycles plus master time.

Optional Feature:
- Macro: CODEC_CFG_VOLUME_EN.
- When defined, add the following ports:
  - vol_req (in, 1)
  - vol_value (in, 7)
  - vol_busy (out, 1)
- In DONE, vol_req=1 latches vol_value and performs two writes, with retry and timeout rules identical to the main sequence:
  - register 0x02 data {2'b01, vol_value}
  - register 0x03 data {2'b01, vol_value}
- Then return to DONE.
- vol_busy is high during the two writes.
- vol_req outside DONE is ignored.
- Failure of a volume write goes to ERROR.
- When the macro is undefined, the ports and logic are absent and behaviour is exactly as above.

Decomposition:
- Package codec_cfg_pkg holds:
  - the state enum
  - WM8731 register address constants
  - the default table as constant arrays cfg_reg[16] (7-bit) and cfg_data[16] (9-bit). Entry 0 is reg 0x0F data 0 (reset); the final entry is reg 0x09 data 1 (active).
- One natural sub-module, cfg_timer: a loadable down-counter with load value, enable and zero flag. It is shared by STARTUP, GAP and timeout, which are mutually exclusive.

Test Plan:
- Normal sequence, NUM_REGS=10 with a master model that acks after 100 cycles:
  - exactly 10 go/end handshakes
  - i2c_data[23:16]=8'h34 on every word
  - cfg_done=1 and cfg_busy=0 after the last end
- Single NACK on entry 3:
  - entry 3 is reissued after GAP_CYCLES with identical i2c_data
  - sequence completes, cfg_error=0
- Persistent NACK on entry 5 with MAX_RETRY=3:
  - 4 attempts on entry 5
  - then cfg_error=1, cfg_index=5
  - no further i2c_go
- Master never ends, TIMEOUT_CYCLES=200:
  - i2c_go drops after 200 cycles per attempt
  - ERROR after 4 attempts on entry 0
- rst_n low during WAIT_END of entry 2:
  - i2c_go=0 immediately
  - after release, STARTUP and then entry 0 is resent
- restart pulse in DONE:
  - full sequence rerun, cfg_index counts 0..9
- restart pulse mid-sequence:
  - no effect
- With CODEC_CFG_VOLUME_EN, vol_req with vol_value=7'h79 in DONE:
  - words {8'h34, 7'h02, 9'h0F9} then {8'h34, 7'h03, 9'h0F9}
  - vol_busy high during the writes, then return to DONE
